// File: rtl/acc_display_ctrl_if.sv
// Control/status bundle of the accumulator display: run/balance in, segments and flags out.
interface acc_display_ctrl_if #(
  parameter int BAL_W      = 4,
  parameter int NUM_DIGITS = 4
);
  logic                    run;
  logic [BAL_W-1:0]        balance;
  logic [7*NUM_DIGITS-1:0] seg;
  logic                    ovf;
  logic                    busy;

  modport master (output run, balance, input seg, ovf, busy);
  modport slave  (input run, balance, output seg, ovf, busy);
endinterface

// File: rtl/acc_display_ctrl.sv
// Prescaled wrap/saturate accumulator, sequential double-dabble to BCD, active-low 7-seg drive.
// New total reaches seg ACC_W+3 cycles after acc is written; no backpressure, updates coalesce.
module acc_display_ctrl #(
  parameter int DIV        = 4,
  parameter int BAL_W      = 4,
  parameter int NUM_DIGITS = 4,
  parameter int MAX_VAL    = 9999,
  parameter int ACC_W      = 14,
  parameter int SAT_MODE   = 0,
  parameter int LZB        = 1
) (
  input  logic             clk,
  input  logic             reset,
  acc_display_ctrl_if.slave bus
);
  localparam int DIV_W = $clog2(DIV);
  localparam int CNT_W = $clog2(ACC_W);
  localparam int BCD_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               acc_evt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum;
  logic               over;
  logic               ovf;
  logic               dirty;
  logic [ACC_W-1:0]   shreg;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   disp;
  logic [CNT_W-1:0]   bit_cnt;
  logic [7*NUM_DIGITS-1:0] seg_v;
  logic               hi_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick    = (div_cnt == DIV_W'(DIV - 1));
  assign acc_evt = tick & bus.run;
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(bus.balance);
  assign over    = (sum > (ACC_W + 1)'(MAX_VAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      ovf   <= 1'b0;
      dirty <= 1'b0;
    end else begin
      if (acc_evt) begin
        if (!over)
          acc <= sum[ACC_W-1:0];
        else if (SAT_MODE != 0)
          acc <= ACC_W'(MAX_VAL);
        else
          acc <= ACC_W'(sum - (ACC_W + 1)'(MAX_VAL + 1));
      end
      if (SAT_MODE != 0)
        ovf <= ovf | (acc_evt & over);
      else
        ovf <= acc_evt & over;
      // A new event in the LOAD cycle must survive so it gets its own conversion
      if (acc_evt)
        dirty <= 1'b1;
      else if (state == LOAD)
        dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dirty) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(ACC_W - 1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bcd     <= '0;
      disp    <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg   <= acc;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          bcd     <= {bcd_adj[BCD_W-2:0], shreg[ACC_W-1]};
          shreg   <= {shreg[ACC_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        UPDATE:  disp <= bcd;
        default: ;
      endcase
    end
  end

  // Walk from the most significant digit so blanking stops at the first nonzero
  always_comb begin
    seg_v   = '0;
    hi_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero && (disp[4*k +: 4] == 4'd0);
      if ((LZB != 0) && (k > 0) && hi_zero)
        seg_v[7*k +: 7] = 7'h7F;
      else
        seg_v[7*k +: 7] = seg7(disp[4*k +: 4]);
    end
  end

  assign bus.seg  = seg_v;
  assign bus.ovf  = ovf;
  assign bus.busy = (state != IDLE);
endmodule
